// File: rtl/pacman_motion.sv
// Grid-locked Pac-Man motion on the 48-pixel maze lattice, one STEP per frame tick.
// Optional pellet tracking and the DONE state are compiled in with `define PACMAN_PELLET_EN.
module pacman_motion #(
  parameter int STEP = 2,
  parameter int SIZE = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [9:0]  Ball_size,
  output logic [1:0]  Dir,
  output logic        moving,
  output logic [87:0] pellets_eaten,
  output logic [6:0]  pellet_count,
  output logic        all_eaten,
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {IDLE, MOVE, BLOCKED, DONE} state_t;

  localparam logic [6:0] STEP_W = 7'(STEP);

  state_t      state_q, state_d;
  logic [1:0]  dir_q, dir_d, req_q, key_dir;
  logic        req_v_q, key_hit, fc_q, fc_prev_q, tick, go, arrive, done_hit;
  logic [3:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic [5:0]  off_q, off_d;
  logic [6:0]  sum;
  logic [9:0]  x_q, y_q, pos_x, pos_y, base_x, base_y, off10;

  function automatic logic nb_exists(input logic [1:0] d, input logic [3:0] c, input logic [2:0] r);
    case (d)
      2'd0:    return c < 4'd10;
      2'd1:    return c != 4'd0;
      2'd2:    return r != 3'd7;
      default: return r != 3'd0;
    endcase
  endfunction

  function automatic logic [6:0] step_tile(input logic [1:0] d, input logic [3:0] c, input logic [2:0] r);
    case (d)
      2'd0:    return {c + 4'd1, r};
      2'd1:    return {c - 4'd1, r};
      2'd2:    return {c, r + 3'd1};
      default: return {c, r - 3'd1};
    endcase
  endfunction

  assign tick = fc_q & ~fc_prev_q;

  always_comb begin
    key_hit = 1'b1;
    key_dir = 2'd0;
    case (keycode)
      8'h07:   key_dir = 2'd0;
      8'h04:   key_dir = 2'd1;
      8'h16:   key_dir = 2'd2;
      8'h1A:   key_dir = 2'd3;
      default: key_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    col_d   = col_q;
    row_d   = row_q;
    off_d   = off_q;
    go      = 1'b0;
    arrive  = 1'b0;
    sum     = 7'd0;
    if (tick) begin
      case (state_q)
        IDLE, BLOCKED: begin
          if (req_v_q && nb_exists(req_q, col_q, row_q)) begin
            dir_d   = req_q;
            state_d = MOVE;
            go      = 1'b1;
          end
        end
        MOVE: begin
          if (req_v_q && req_q == (dir_q ^ 2'd1)) begin
            // The tile we were heading for becomes the reference centre.
            dir_d = req_q;
            go    = 1'b1;
            if (off_q != 6'd0) begin
              off_d          = 6'd48 - off_q;
              {col_d, row_d} = step_tile(dir_q, col_q, row_q);
            end
          end else if (off_q == 6'd0) begin
            if (req_v_q && nb_exists(req_q, col_q, row_q)) begin
              dir_d = req_q;
              go    = 1'b1;
            end else if (nb_exists(dir_q, col_q, row_q)) begin
              go = 1'b1;
            end else begin
              state_d = BLOCKED;
            end
          end else begin
            go = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (go) begin
      sum = {1'b0, off_d} + STEP_W;
      if (sum >= 7'd48) begin
        off_d          = 6'd0;
        {col_d, row_d} = step_tile(dir_d, col_d, row_d);
        arrive         = 1'b1;
      end else begin
        off_d = sum[5:0];
      end
    end
  end

  always_comb begin
    base_x = 10'd72 + 10'(col_q) * 10'd48;
    base_y = 10'd72 + 10'(row_q) * 10'd48;
    off10  = 10'(off_q);
    pos_x  = base_x;
    pos_y  = base_y;
    case (dir_q)
      2'd0:    pos_x = base_x + off10;
      2'd1:    pos_x = base_x - off10;
      2'd2:    pos_y = base_y + off10;
      default: pos_y = base_y - off10;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_q      <= 1'b0;
      fc_prev_q <= 1'b0;
      req_q     <= 2'd0;
      req_v_q   <= 1'b0;
      state_q   <= IDLE;
      dir_q     <= 2'd0;
      col_q     <= 4'd5;
      row_q     <= 3'd4;
      off_q     <= 6'd0;
      x_q       <= 10'd312;
      y_q       <= 10'd264;
    end else begin
      fc_q      <= frame_clk;
      fc_prev_q <= fc_q;
      if (key_hit) begin
        req_q   <= key_dir;
        req_v_q <= 1'b1;
      end
      state_q <= done_hit ? DONE : state_d;
      dir_q   <= dir_d;
      col_q   <= col_d;
      row_q   <= row_d;
      off_q   <= off_d;
      x_q     <= pos_x;
      y_q     <= pos_y;
    end
  end

`ifdef PACMAN_PELLET_EN
  logic [87:0] pel_q, pel_d;
  logic [6:0]  cnt_q, cnt_d, pel_idx;

  always_comb begin
    pel_idx  = 7'(row_d) * 7'd11 + 7'(col_d);
    pel_d    = pel_q;
    cnt_d    = cnt_q;
    done_hit = 1'b0;
    if (arrive && !pel_q[pel_idx]) begin
      pel_d[pel_idx] = 1'b1;
      cnt_d          = cnt_q + 7'd1;
      done_hit       = (cnt_q == 7'd87);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pel_q     <= 88'd0;
      pel_q[49] <= 1'b1;
      cnt_q     <= 7'd1;
    end else begin
      pel_q <= pel_d;
      cnt_q <= cnt_d;
    end
  end

  assign pellets_eaten = pel_q;
  assign pellet_count  = cnt_q;
  assign all_eaten     = (cnt_q == 7'd88);
`else
  logic unused_arrive;
  assign unused_arrive = arrive;
  assign done_hit      = 1'b0;
  assign pellets_eaten = 88'd0;
  assign pellet_count  = 7'd0;
  assign all_eaten     = 1'b0;
`endif

  assign BallX     = x_q;
  assign BallY     = y_q;
  assign Ball_size = 10'(SIZE);
  assign Dir       = dir_q;
  assign moving    = (state_q == MOVE);
  assign state_o   = state_q;
endmodule

// File: tb/tb_pacman_motion.sv
// Bench for pacman_motion: a pixel-level reference model feeds an expected queue per frame tick.
module tb_pacman_motion;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'h00;
  logic [9:0]  BallX, BallY, Ball_size;
  logic [1:0]  Dir, state_o;
  logic        moving, all_eaten;
  logic [87:0] pellets_eaten;
  logic [6:0]  pellet_count;

`ifdef PACMAN_PELLET_EN
  localparam bit PEL_EN = 1'b1;
`else
  localparam bit PEL_EN = 1'b0;
`endif
  localparam int STEP = 2;

  pacman_motion #(.STEP(STEP), .SIZE(10)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size), .Dir(Dir), .moving(moving),
    .pellets_eaten(pellets_eaten), .pellet_count(pellet_count), .all_eaten(all_eaten),
    .state_o(state_o)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state in pixels
  int          m_x, m_y, m_cnt;
  logic [1:0]  m_dir, m_state, m_req;
  bit          m_req_v;
  logic [87:0] m_pel;
  logic [31:0] exp_q[$];

  function automatic void model_reset();
    m_x = 312; m_y = 264; m_dir = 2'd0; m_state = 2'd0;
    m_req = 2'd0; m_req_v = 1'b0; m_pel = '0; m_pel[49] = 1'b1; m_cnt = 1;
  endfunction

  function automatic bit m_centred(int x, int y);
    return ((x - 72) % 48 == 0) && ((y - 72) % 48 == 0);
  endfunction

  function automatic bit m_exists(logic [1:0] d, int x, int y);
    case (d)
      2'd0:    return x + 48 <= 552;
      2'd1:    return x - 48 >= 72;
      2'd2:    return y + 48 <= 408;
      default: return y - 48 >= 72;
    endcase
  endfunction

  function automatic void model_key(logic [7:0] k);
    case (k)
      8'h07: begin m_req = 2'd0; m_req_v = 1'b1; end
      8'h04: begin m_req = 2'd1; m_req_v = 1'b1; end
      8'h16: begin m_req = 2'd2; m_req_v = 1'b1; end
      8'h1A: begin m_req = 2'd3; m_req_v = 1'b1; end
      default: ;
    endcase
  endfunction

  function automatic void model_tick();
    bit go = 1'b0;
    int idx;
    case (m_state)
      2'd0, 2'd2: if (m_req_v && m_exists(m_req, m_x, m_y)) begin
        m_dir = m_req; m_state = 2'd1; go = 1'b1;
      end
      2'd1: begin
        if (m_req_v && m_req == (m_dir ^ 2'd1)) begin
          m_dir = m_req; go = 1'b1;
        end else if (m_centred(m_x, m_y)) begin
          if (m_req_v && m_exists(m_req, m_x, m_y)) begin m_dir = m_req; go = 1'b1; end
          else if (m_exists(m_dir, m_x, m_y)) go = 1'b1;
          else m_state = 2'd2;
        end else go = 1'b1;
      end
      default: ;
    endcase
    if (go) begin
      case (m_dir)
        2'd0:    m_x = m_x + STEP;
        2'd1:    m_x = m_x - STEP;
        2'd2:    m_y = m_y + STEP;
        default: m_y = m_y - STEP;
      endcase
      if (m_centred(m_x, m_y)) begin
        idx = ((m_y - 72) / 48) * 11 + (m_x - 72) / 48;
        if (!m_pel[idx]) begin
          m_pel[idx] = 1'b1;
          m_cnt++;
          if (PEL_EN && m_cnt == 88) m_state = 2'd3;
        end
      end
    end
  endfunction

  function automatic logic [31:0] m_pack();
    return {10'(m_x), 10'(m_y), m_dir, m_state, (m_state == 2'd1), PEL_EN ? 7'(m_cnt) : 7'd0};
  endfunction

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic press(input logic [7:0] k);
    @(negedge Clk);
    keycode = k;
    model_key(k);
    @(negedge Clk);
    keycode = 8'h00;
  endtask

  // One frame tick; race_key lands in the tick cycle itself and must not affect that tick.
  task automatic do_tick(input logic [7:0] race_key);
    logic [31:0] got, exp;
    model_tick();
    exp_q.push_back(m_pack());
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0; keycode = race_key; model_key(race_key);
    @(negedge Clk); keycode = 8'h00;
    @(posedge Clk); #1;
    got = {BallX, BallY, Dir, state_o, moving, pellet_count};
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL tick: got x=%0d y=%0d dir=%0d st=%0d mv=%0b cnt=%0d, exp x=%0d y=%0d dir=%0d st=%0d mv=%0b cnt=%0d",
               got[31:22], got[21:12], got[11:10], got[9:8], got[7], got[6:0],
               exp[31:22], exp[21:12], exp[11:10], exp[9:8], exp[7], exp[6:0]);
    end
  endtask

  task automatic test_reset();
    logic [87:0] e_pel;
    e_pel = '0;
    e_pel[49] = PEL_EN;
    apply_reset();
    @(posedge Clk); #1;
    n_tests++; if (BallX !== 10'd312) begin n_fail++; $display("FAIL reset_x: got %0d exp 312", BallX); end
    n_tests++; if (BallY !== 10'd264) begin n_fail++; $display("FAIL reset_y: got %0d exp 264", BallY); end
    n_tests++; if (Dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir: got %0d exp 0", Dir); end
    n_tests++; if (moving !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %0b exp 0", moving); end
    n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_o); end
    n_tests++; if (Ball_size !== 10'd10) begin n_fail++; $display("FAIL ball_size: got %0d exp 10", Ball_size); end
    n_tests++; if (pellet_count !== (PEL_EN ? 7'd1 : 7'd0)) begin n_fail++; $display("FAIL reset_count: got %0d exp %0d", pellet_count, PEL_EN ? 1 : 0); end
    n_tests++; if (pellets_eaten !== e_pel) begin n_fail++; $display("FAIL reset_pellets: got %h exp %h", pellets_eaten, e_pel); end
    n_tests++; if (all_eaten !== 1'b0) begin n_fail++; $display("FAIL reset_all_eaten: got %0b exp 0", all_eaten); end
  endtask

  task automatic test_move_right();
    apply_reset();
    press(8'h07);
    repeat (24) do_tick(8'h00);
    n_tests++; if (BallX !== 10'd360) begin n_fail++; $display("FAIL right_x: got %0d exp 360", BallX); end
    n_tests++; if (moving !== 1'b1) begin n_fail++; $display("FAIL right_moving: got %0b exp 1", moving); end
    n_tests++; if (pellets_eaten[50] !== PEL_EN) begin n_fail++; $display("FAIL right_bit50: got %0b exp %0b", pellets_eaten[50], PEL_EN); end
    n_tests++; if (pellet_count !== (PEL_EN ? 7'd2 : 7'd0)) begin n_fail++; $display("FAIL right_count: got %0d exp %0d", pellet_count, PEL_EN ? 2 : 0); end
  endtask

  task automatic test_queued_turn();
    apply_reset();
    press(8'h07);
    repeat (5) do_tick(8'h00);
    press(8'h1A);
    repeat (43) do_tick(8'h00);
    n_tests++; if (BallX !== 10'd360 || BallY !== 10'd216 || Dir !== 2'd3) begin
      n_fail++; $display("FAIL queued_turn: got x=%0d y=%0d dir=%0d exp x=360 y=216 dir=3", BallX, BallY, Dir);
    end
  endtask

  task automatic test_edge();
    apply_reset();
    press(8'h07);
    repeat (120) do_tick(8'h00);
    n_tests++; if (BallX !== 10'd552) begin n_fail++; $display("FAIL edge_reach: got %0d exp 552", BallX); end
    repeat (11) do_tick(8'h00);
    n_tests++; if (state_o !== 2'd2 || moving !== 1'b0 || BallX !== 10'd552) begin
      n_fail++; $display("FAIL edge_blocked: got st=%0d mv=%0b x=%0d exp st=2 mv=0 x=552", state_o, moving, BallX);
    end
    press(8'h04);
    do_tick(8'h00);
    n_tests++; if (BallX !== 10'd550 || moving !== 1'b1) begin
      n_fail++; $display("FAIL edge_leave: got x=%0d mv=%0b exp x=550 mv=1", BallX, moving);
    end
  endtask

  task automatic test_reverse();
    apply_reset();
    press(8'h07);
    repeat (9) do_tick(8'h00);
    press(8'h04);
    do_tick(8'h00);
    n_tests++; if (BallX !== 10'd328 || Dir !== 2'd1 || moving !== 1'b1) begin
      n_fail++; $display("FAIL reverse: got x=%0d dir=%0d mv=%0b exp x=328 dir=1 mv=1", BallX, Dir, moving);
    end
  endtask

  task automatic test_race();
    apply_reset();
    press(8'h07);
    repeat (3) do_tick(8'h00);
    do_tick(8'h04);
    n_tests++; if (BallX !== 10'd320 || Dir !== 2'd0) begin
      n_fail++; $display("FAIL race_old_req: got x=%0d dir=%0d exp x=320 dir=0", BallX, Dir);
    end
    do_tick(8'h00);
    n_tests++; if (BallX !== 10'd318 || Dir !== 2'd1) begin
      n_fail++; $display("FAIL race_new_req: got x=%0d dir=%0d exp x=318 dir=1", BallX, Dir);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    press(8'h07);
    repeat (14) do_tick(8'h00);
    n_tests++; if (BallX !== 10'd340) begin n_fail++; $display("FAIL mid_pre_x: got %0d exp 340", BallX); end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    n_tests++; if (BallX !== 10'd312 || BallY !== 10'd264 || state_o !== 2'd0 || pellet_count !== (PEL_EN ? 7'd1 : 7'd0)) begin
      n_fail++; $display("FAIL mid_reset: got x=%0d y=%0d st=%0d cnt=%0d exp x=312 y=264 st=0 cnt=%0d",
                         BallX, BallY, state_o, pellet_count, PEL_EN ? 1 : 0);
    end
    @(negedge Clk); Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [7:0] keys [6];
    logic [87:0] e_pel;
    keys = '{8'h07, 8'h04, 8'h16, 8'h1A, 8'h00, 8'h2C};
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) press(keys[$urandom_range(0, 5)]);
      do_tick(($urandom_range(0, 7) == 0) ? keys[$urandom_range(0, 5)] : 8'h00);
    end
    e_pel = PEL_EN ? m_pel : 88'd0;
    n_tests++; if (pellets_eaten !== e_pel) begin n_fail++; $display("FAIL random_pellets: got %h exp %h", pellets_eaten, e_pel); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL queue_drain: got %0d left exp 0", exp_q.size()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_move_right();
    test_queued_turn();
    test_edge();
    test_reverse();
    test_race();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
